// File: rtl/instr_issuer_pkg.sv
// rtl/instr_issuer_pkg.sv - opcode map, instruction field layout and FSM states for instr_issuer
package instr_issuer_pkg;

  localparam logic [3:0] OP_IMM_FIRST = 4'd6;
  localparam logic [3:0] OP_IMM_LAST  = 4'd10;
  localparam logic [3:0] OP_HALT      = 4'd15;

  localparam int FIELD_W = 4;
  localparam int OPC_LSB = 12;
  localparam int RC_LSB  = 8;
  localparam int RA_LSB  = 4;
  localparam int RB_LSB  = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_ISSUE,
    ST_WB,
    ST_HALT
  } state_t;

  function automatic logic is_imm_op(input logic [3:0] op);
    return (op >= OP_IMM_FIRST) && (op <= OP_IMM_LAST);
  endfunction

endpackage

// File: rtl/instr_buffer.sv
// rtl/instr_buffer.sv - program store: DEPTH x 16 words, append-only write, asynchronous read
module instr_buffer #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH),
  parameter int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [15:0]   wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [15:0]   rd_data,
  output logic [CW-1:0] count,
  output logic          full
);

  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;

  assign full    = (count == CW'(DEPTH));
  assign rd_data = mem[rd_addr];

  // Contents survive reset; count=0 alone makes stale words unreachable.
  always_ff @(posedge clk) begin
    if (wr_en && !full) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      count  <= '0;
    end else if (wr_en && !full) begin
      wr_ptr <= wr_ptr + 1'b1;
      count  <= count + 1'b1;
    end
  end

endmodule

// File: rtl/instr_issuer.sv
// rtl/instr_issuer.sv - program buffer playback and instruction issue FSM; INSTR_ISSUER_STEP_EN adds single-step gating
module instr_issuer
  import instr_issuer_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_valid,
  input  logic [15:0] load_instr,
  output logic        load_ready,
  input  logic        run,
  input  logic        step,
  output logic        iss_valid,
  input  logic        iss_ready,
  output logic [3:0]  iss_opcode,
  output logic [3:0]  iss_rc,
  output logic [3:0]  iss_ra,
  output logic [3:0]  iss_rb,
  output logic [15:0] iss_imm,
  output logic        iss_imm_sel,
  output logic        iss_wr,
  output logic [3:0]  pc,
  output logic        halted
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  state_t        state;
  logic [CW-1:0] count;
  logic          full;
  logic [15:0]   word;
  logic [3:0]    opc;
  logic          load_en;
  logic          advance;

  assign load_ready = (state == ST_IDLE) && !full;
  assign load_en    = load_valid && load_ready;
  assign opc        = word[OPC_LSB +: FIELD_W];

  instr_buffer #(.DEPTH(DEPTH)) u_buffer (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (load_en),
    .wr_data (load_instr),
    .rd_addr (pc[AW-1:0]),
    .rd_data (word),
    .count   (count),
    .full    (full)
  );

`ifdef INSTR_ISSUER_STEP_EN
  logic step_q;
  logic step_pending;
  logic step_edge;

  assign step_edge = step && !step_q;
  assign advance   = step_pending || step_edge;

  // An edge seen while the current instruction is in flight is kept for its WB.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      step_q       <= 1'b0;
      step_pending <= 1'b0;
    end else begin
      step_q <= step;
      case (state)
        ST_FETCH, ST_ISSUE: if (step_edge) step_pending <= 1'b1;
        default:            step_pending <= 1'b0;
      endcase
    end
  end
`else
  logic unused_step;
  assign unused_step = step;
  assign advance     = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      pc          <= '0;
      halted      <= 1'b0;
      iss_valid   <= 1'b0;
      iss_wr      <= 1'b0;
      iss_opcode  <= '0;
      iss_rc      <= '0;
      iss_ra      <= '0;
      iss_rb      <= '0;
      iss_imm     <= '0;
      iss_imm_sel <= 1'b0;
    end else begin
      iss_wr <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (run && (count != '0)) state <= ST_FETCH;
        end
        ST_FETCH: begin
          if (opc == OP_HALT) begin
            state  <= ST_HALT;
            halted <= 1'b1;
          end else if (opc > OP_IMM_LAST) begin
            state <= ST_WB;
          end else begin
            state       <= ST_ISSUE;
            iss_valid   <= 1'b1;
            iss_opcode  <= opc;
            iss_rc      <= word[RC_LSB +: FIELD_W];
            iss_rb      <= word[RB_LSB +: FIELD_W];
            iss_imm_sel <= is_imm_op(opc);
            if (is_imm_op(opc)) begin
              iss_ra  <= '0;
              iss_imm <= {12'd0, word[RA_LSB +: FIELD_W]};
            end else begin
              iss_ra  <= word[RA_LSB +: FIELD_W];
              iss_imm <= '0;
            end
          end
        end
        ST_ISSUE: begin
          if (iss_ready) begin
            iss_valid <= 1'b0;
            iss_wr    <= 1'b1;
            state     <= ST_WB;
          end
        end
        ST_WB: begin
          if (advance) begin
            if (({1'b0, pc} + 5'd1) < 5'(count)) begin
              pc    <= pc + 4'd1;
              state <= ST_FETCH;
            end else begin
              state  <= ST_HALT;
              halted <= 1'b1;
            end
          end
        end
        ST_HALT: begin
          if (!run) begin
            state  <= ST_IDLE;
            pc     <= '0;
            halted <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_issuer.sv
// tb/tb_instr_issuer.sv - self-checking bench for instr_issuer with a program-level reference model
module tb_instr_issuer;

  logic        clk = 1'b0;
  logic        rst_n, load_valid, run, step, iss_ready;
  logic [15:0] load_instr;
  logic        load_ready, iss_valid, iss_imm_sel, iss_wr, halted;
  logic [3:0]  iss_opcode, iss_rc, iss_ra, iss_rb, pc;
  logic [15:0] iss_imm;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;
  int wr_cnt = 0;
  int acc_cnt = 0;

  logic [32:0] obs_q[$];
  int          hs_cyc[$];
  logic [15:0] prog_q[$];
  logic [32:0] exp_q[$];
  int          exp_pc;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  instr_issuer #(.DEPTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_instr(load_instr),
    .load_ready(load_ready), .run(run), .step(step), .iss_valid(iss_valid),
    .iss_ready(iss_ready), .iss_opcode(iss_opcode), .iss_rc(iss_rc), .iss_ra(iss_ra),
    .iss_rb(iss_rb), .iss_imm(iss_imm), .iss_imm_sel(iss_imm_sel), .iss_wr(iss_wr),
    .pc(pc), .halted(halted)
  );

  function automatic logic [32:0] fields();
    return {iss_opcode, iss_rc, iss_ra, iss_rb, iss_imm_sel, iss_imm};
  endfunction

  // What the datapath should see for one instruction word, straight from the opcode map.
  function automatic logic [32:0] expect_fields(input logic [15:0] w);
    logic [3:0] op;
    op = w[15:12];
    if (op <= 4'd5) return {op, w[11:8], w[7:4], w[3:0], 1'b0, 16'd0};
    return {op, w[11:8], 4'd0, w[3:0], 1'b1, 12'd0, w[7:4]};
  endfunction

  // Walk the program: HALT stops, NOPs vanish, everything else is issued once in order.
  function automatic void build_expect();
    logic [3:0] op;
    exp_q.delete();
    exp_pc = 0;
    for (int i = 0; i < prog_q.size() && i < 16; i++) begin
      op = prog_q[i][15:12];
      exp_pc = i;
      if (op == 4'd15) break;
      if (op <= 4'd10) exp_q.push_back(expect_fields(prog_q[i]));
    end
  endfunction

  always @(negedge clk) begin
    if (iss_valid && iss_ready) begin
      obs_q.push_back(fields());
      hs_cyc.push_back(cyc);
    end
    if (iss_wr) wr_cnt++;
    if (load_valid && load_ready) acc_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0; load_valid = 1'b0; load_instr = '0;
    run = 1'b0; step = 1'b0; iss_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    obs_q.delete(); hs_cyc.delete();
    wr_cnt = 0; acc_cnt = 0;
  endtask

  task automatic load_prog(input bit gaps);
    foreach (prog_q[i]) begin
      load_valid = 1'b1;
      load_instr = prog_q[i];
      @(posedge clk); #1;
      load_valid = 1'b0;
      if (gaps && ($urandom_range(0, 1) == 1)) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic run_to_halt(input bit rnd, input int lim, output bit ok);
    ok  = 1'b0;
    run = 1'b1;
    for (int i = 0; i < lim; i++) begin
      @(posedge clk); #1;
      step = ~step;
      if (rnd) iss_ready = 1'($urandom_range(0, 1));
      if (halted) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (iss_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    bit ok;
    int run_cyc;
    int n;

    do_reset();
    check("rst_load_ready", 64'(load_ready), 64'd1);
    check("rst_iss_valid", 64'(iss_valid), 64'd0);
    check("rst_iss_wr", 64'(iss_wr), 64'd0);
    check("rst_halted", 64'(halted), 64'd0);
    check("rst_pc", 64'(pc), 64'd0);
    check("rst_fields", 64'(fields()), 64'd0);

    // Two-instruction program ending in HALT, datapath always ready.
    prog_q = '{16'h1321, 16'h6452, 16'hF000};
    load_prog(1'b0);
    iss_ready = 1'b1;
    run_cyc = cyc;
    run_to_halt(1'b0, 60, ok);
    check("basic_halt_reached", 64'(ok), 64'd1);
    check("basic_issue_count", 64'(obs_q.size()), 64'd2);
    if (obs_q.size() >= 2) begin
      check("basic_issue0", 64'(obs_q[0]), 64'({4'd1, 4'd3, 4'd2, 4'd1, 1'b0, 16'd0}));
      check("basic_issue1", 64'(obs_q[1]), 64'({4'd6, 4'd4, 4'd0, 4'd2, 1'b1, 16'h0005}));
      check("first_issue_latency", 64'(hs_cyc[0] - run_cyc), 64'd2);
      check("issue_spacing", 64'(hs_cyc[1] - hs_cyc[0]), 64'd3);
    end
    check("basic_wr_count", 64'(wr_cnt), 64'd2);
    check("basic_halted", 64'(halted), 64'd1);
    check("basic_pc", 64'(pc), 64'd2);
    run = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("idle_halted_clear", 64'(halted), 64'd0);
    check("idle_pc_clear", 64'(pc), 64'd0);
    obs_q.delete();
    run_to_halt(1'b0, 60, ok);
    check("replay_halt_reached", 64'(ok), 64'd1);
    check("replay_issue_count", 64'(obs_q.size()), 64'd2);
    check("replay_wr_count", 64'(wr_cnt), 64'd4);

    // Seventeen words offered back to back: only sixteen fit.
    do_reset();
    prog_q.delete();
    for (int i = 0; i < 17; i++) prog_q.push_back(16'($urandom));
    for (int i = 0; i < 17; i++) begin
      load_valid = 1'b1;
      load_instr = prog_q[i];
      @(posedge clk); #1;
    end
    load_valid = 1'b0;
    check("full_accepted", 64'(acc_cnt), 64'd16);
    check("full_load_ready", 64'(load_ready), 64'd0);
    void'(prog_q.pop_back());
    build_expect();
    run_to_halt(1'b1, 800, ok);
    check("full_halt_reached", 64'(ok), 64'd1);
    check("full_issue_count", 64'(obs_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      check("full_issue_fields", 64'(obs_q[i]), 64'(exp_q[i]));
    check("full_pc", 64'(pc), 64'(exp_pc));

    // Back-pressure during ISSUE.
    do_reset();
    prog_q = '{16'h7ABC};
    load_prog(1'b0);
    run = 1'b1;
    wait_valid(ok);
    check("stall_valid_seen", 64'(ok), 64'd1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("stall_fields", 64'(fields()), 64'(expect_fields(16'h7ABC)));
      check("stall_no_wr", 64'(iss_wr), 64'd0);
    end
    @(posedge clk); #1;
    iss_ready = 1'b1;
    @(negedge clk);
    check("stall_wr_before_edge", 64'(iss_wr), 64'd0);
    @(negedge clk);
    check("stall_wr_pulse", 64'(iss_wr), 64'd1);
    @(negedge clk);
    check("stall_wr_done", 64'(iss_wr), 64'd0);
    check("stall_wr_count", 64'(wr_cnt), 64'd1);

    // NOP is skipped without reaching the datapath.
    do_reset();
    prog_q = '{16'hB123, 16'h0210};
    load_prog(1'b0);
    build_expect();
    iss_ready = 1'b1;
    run_to_halt(1'b0, 60, ok);
    check("nop_halt_reached", 64'(ok), 64'd1);
    check("nop_issue_count", 64'(obs_q.size()), 64'd1);
    if (obs_q.size() >= 1) check("nop_issue_fields", 64'(obs_q[0]), 64'(exp_q[0]));
    check("nop_wr_count", 64'(wr_cnt), 64'd1);
    check("nop_pc", 64'(pc), 64'(exp_pc));

    // Reset while an instruction waits in ISSUE.
    do_reset();
    prog_q = '{16'h1321};
    load_prog(1'b0);
    run = 1'b1;
    wait_valid(ok);
    check("abort_valid_seen", 64'(ok), 64'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    iss_ready = 1'b1;
    check("abort_iss_valid", 64'(iss_valid), 64'd0);
    check("abort_load_ready", 64'(load_ready), 64'd1);
    check("abort_iss_wr", 64'(iss_wr), 64'd0);
    repeat (10) begin
      @(posedge clk); #1;
    end
    check("abort_no_issue", 64'(obs_q.size()), 64'd0);
    check("abort_no_wr", 64'(wr_cnt), 64'd0);
    check("abort_stays_idle", 64'(load_ready), 64'd1);

    // Three-instruction program with step held low.
    do_reset();
    prog_q = '{16'h1321, 16'h1322, 16'h1323};
    load_prog(1'b0);
    iss_ready = 1'b1;
`ifdef INSTR_ISSUER_STEP_EN
    run = 1'b1;
    repeat (15) begin
      @(posedge clk); #1;
    end
    check("step_stall_issues", 64'(obs_q.size()), 64'd1);
    check("step_stall_wr", 64'(wr_cnt), 64'd1);
    check("step_stall_halted", 64'(halted), 64'd0);
    step = 1'b1;
    @(posedge clk); #1;
    step = 1'b0;
    repeat (15) begin
      @(posedge clk); #1;
    end
    check("step_one_more_issue", 64'(obs_q.size()), 64'd2);
    check("step_still_running", 64'(halted), 64'd0);
`else
    run = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (halted) begin
        ok = 1'b1;
        break;
      end
    end
    check("nostep_halt_reached", 64'(ok), 64'd1);
    check("nostep_issues", 64'(obs_q.size()), 64'd3);
`endif

    // Randomized programs, loading gaps and back-pressure against the model.
    for (int it = 0; it < 6; it++) begin
      do_reset();
      prog_q.delete();
      n = int'($urandom_range(1, 16));
      for (int i = 0; i < n; i++) prog_q.push_back(16'($urandom));
      load_prog(1'b1);
      build_expect();
      run_to_halt(1'b1, 800, ok);
      check("rand_halt_reached", 64'(ok), 64'd1);
      check("rand_issue_count", 64'(obs_q.size()), 64'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
        check("rand_issue_fields", 64'(obs_q[i]), 64'(exp_q[i]));
      check("rand_wr_count", 64'(wr_cnt), 64'(exp_q.size()));
      check("rand_pc", 64'(pc), 64'(exp_pc));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/instr_issuer.md
INSTR_ISSUER -- requirements
Module: instr_issuer

Interface
REQ-001 Parameter DEPTH, default 16, program buffer entries (power of two, 2..16).
REQ-002 clk  input  1  system clock, all logic on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 load_valid  input  1  load_instr is valid.
REQ-005 load_instr  input  16  instruction word: [15:12] opcode, [11:8] rc, [7:4] ra/imm, [3:0] rb.
REQ-006 load_ready  output  1  buffer accepts a word.
REQ-007 run  input  1  level; starts program playback from IDLE.
REQ-008 step  input  1  single-step request, level sampled for rising edge.
REQ-009 iss_valid  output  1  issued instruction fields valid.
REQ-010 iss_ready  input  1  datapath accepts issued instruction.
REQ-011 iss_opcode, iss_rc, iss_ra, iss_rb  output  4 each  decoded fields.
REQ-012 iss_imm  output  16  zero-extended immediate.
REQ-013 iss_imm_sel  output  1  1 = immediate form.
REQ-014 iss_wr  output  1  register-bank write strobe, one cycle.
REQ-015 pc  output  4  index of current instruction.
REQ-016 halted  output  1  playback finished.

Function
REQ-017 States IDLE, FETCH, ISSUE, WB, HALT; IDLE->FETCH when run=1 and count>0; FETCH->ISSUE next cycle; ISSUE->WB on iss_valid&iss_ready; WB->FETCH (pc+1<count) else HALT; HALT->IDLE when run=0.
REQ-018 Loading only in IDLE: load_ready=1 when IDLE and count<DEPTH; word written at wr_ptr, wr_ptr and count increment on load_valid&load_ready.
REQ-019 Buffer full (count=DEPTH): load_ready=0, load_valid ignored, no wrap or overwrite.
REQ-020 Returning HALT->IDLE keeps buffer contents; pc cleared to 0; a new run replays the same program.
REQ-021 Opcodes 0-5: iss_ra=[7:4], iss_rb=[3:0], iss_imm_sel=0, iss_imm=0.
REQ-022 Opcodes 6-10: iss_imm={12'd0,[7:4]}, iss_rb=[3:0], iss_ra=0, iss_imm_sel=1.
REQ-023 iss_rc=[11:8] and iss_opcode=[15:12] for opcodes 0-10.
REQ-024 Opcodes 11-14: NOP; FETCH->WB with no iss_valid and no iss_wr.
REQ-025 Opcode 15: HALT; FETCH->HALT immediately, no issue.
REQ-026 iss_valid=1 only in ISSUE; fields stable while iss_valid=1 and iss_ready=0.
REQ-027 iss_wr=1 exactly in WB for opcodes 0-10 (one cycle after handshake).
REQ-028 Latency run-to-first iss_valid: 2 cycles; back-to-back issue spacing with iss_ready=1: 3 cycles.
REQ-029 halted=1 only in HALT.
REQ-030 load_valid outside IDLE ignored; run deassertion mid-program ignored until HALT.

Reset
REQ-031 rst_n=0 at a clock edge: state=IDLE, count=0, wr_ptr=0, pc=0, step edge register=0, all iss_* outputs 0, halted=0, load_ready=1 from the next cycle.
REQ-032 Reset mid-operation aborts any pending issue without iss_wr; buffer contents need not be cleared but count=0 makes them unreachable.

Configuration
REQ-033 Macro INSTR_ISSUER_STEP_EN defined: WB->FETCH additionally waits for a step rising edge (step=1, previous sample 0); an edge in WB or earlier in the same instruction is held pending until consumed.
REQ-034 Macro undefined: step ignored, WB->FETCH unconditional per REQ-017.

Structure
REQ-035 Shared package holds opcode constants (OP_ADD..OP_IMM_LAST=10, OP_HALT=15), field bit ranges, state enum.
REQ-036 One sub-module instr_buffer: DEPTH x 16 storage with write pointer, count, full flag, asynchronous read by pc.

Verification
REQ-037 Load 0x1321, 0x6452, 0xF000, run=1, iss_ready=1 -> issue opcode 1 rc3 ra2 rb1, then opcode 6 rc4 imm=0x0005 rb2 imm_sel=1, iss_wr twice, halted=1, pc=2.
REQ-038 Load 17 words with load_valid held -> exactly 16 accepted, load_ready=0 after 16th.
REQ-039 iss_ready low for 5 cycles during ISSUE -> fields stable, iss_wr only one cycle after iss_ready rises.
REQ-040 Program 0xB123, 0x0210 -> first is NOP (no iss_valid), second issued, one iss_wr total.
REQ-041 rst_n=0 while ISSUE -> next cycle IDLE, iss_valid=0, count=0, no iss_wr.
REQ-042 With INSTR_ISSUER_STEP_EN, 3-instruction program, no step -> stalls in WB after first; one step pulse -> exactly one further issue.
